// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM write-side controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        CAM_OP_FILL       = 2'd0,
        CAM_OP_INVALIDATE = 2'd1,
        CAM_OP_FLUSH      = 2'd2
    } cam_op_t;

    // Controller state encoding kept as plain constants so older blocks
    // that compare raw state bits keep working.
    typedef logic [1:0] cam_ctrl_state_t;

    localparam cam_ctrl_state_t ST_IDLE  = 2'd0;
    localparam cam_ctrl_state_t ST_PROBE = 2'd1;
    localparam cam_ctrl_state_t ST_WRITE = 2'd2;
    localparam cam_ctrl_state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/cam_free_slot_finder.sv
// Lowest-clear-bit priority encoder over the slot valid mirror.
// Latency: purely combinational.
// Backpressure: none; any_free=0 tells the caller to fall back to eviction.
module cam_free_slot_finder #(
    parameter int NUM_ENTRIES = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] slot_valid,
    output logic [INDEX_WIDTH-1:0] free_index,
    output logic                   any_free
);

    // Scan from the top down so the lowest clear bit wins last.
    always_comb begin
        any_free   = 1'b0;
        free_index = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                any_free   = 1'b1;
                free_index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/cam_update_ctrl.sv
// Write-side CAM controller: fill with duplicate probe, invalidate, flush walk.
// Latency: accept at T -> update/response at T+2 -> ready at T+3; flush takes NUM_ENTRIES cycles.
// Backpressure: req_ready only in IDLE, so a single request is in flight at a time.
module cam_update_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    output logic [KEY_WIDTH-1:0]   cam_lookup_key,
    input  logic                   cam_lookup_hit,
    input  logic [INDEX_WIDTH-1:0] cam_lookup_index,
    output logic                   update_en,
    output logic [KEY_WIDTH-1:0]   update_key,
    output logic [INDEX_WIDTH-1:0] update_index,
    output logic                   update_valid,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [INDEX_WIDTH-1:0] resp_index
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

    cam_ctrl_state_t          state;
    cam_op_t                  op_q;
    logic [KEY_WIDTH-1:0]     key_q;
    logic                     hit_q;
    logic [INDEX_WIDTH-1:0]   hit_idx_q;
    logic [INDEX_WIDTH-1:0]   walk_cnt;
    logic [INDEX_WIDTH-1:0]   rr_ptr;
    logic [NUM_ENTRIES-1:0]   slot_valid;

    logic [INDEX_WIDTH-1:0]   free_index;
    logic                     any_free;
    logic [INDEX_WIDTH-1:0]   victim;
    logic [INDEX_WIDTH-1:0]   rr_next;
    logic [INDEX_WIDTH-1:0]   walk_next;

    cam_free_slot_finder #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_free_slot_finder (
        .slot_valid (slot_valid),
        .free_index (free_index),
        .any_free   (any_free)
    );

    assign req_ready      = (state == ST_IDLE);
    assign cam_lookup_key = key_q;
    assign victim         = any_free ? free_index : rr_ptr;
    assign rr_next        = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
    assign walk_next      = walk_cnt + 1'b1;

    // Request sequencing; the WRITE-cycle outputs are registered at the end
    // of PROBE from the live lookup result so they are visible during WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= CAM_OP_FILL;
            key_q        <= '0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            walk_cnt     <= '0;
            rr_ptr       <= '0;
            update_en    <= 1'b0;
            update_key   <= '0;
            update_index <= '0;
            update_valid <= 1'b0;
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            resp_index   <= '0;
        end else begin
            update_en  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q  <= cam_op_t'(req_op);
                        key_q <= req_key;
                        if (req_op == CAM_OP_FLUSH) begin
                            // First walk slot goes out right away.
                            state        <= ST_FLUSH;
                            walk_cnt     <= '0;
                            update_en    <= 1'b1;
                            update_valid <= 1'b0;
                            update_key   <= '0;
                            update_index <= '0;
                        end else begin
                            state <= ST_PROBE;
                        end
                    end
                end
                ST_PROBE: begin
                    hit_q      <= cam_lookup_hit;
                    hit_idx_q  <= cam_lookup_index;
                    state      <= ST_WRITE;
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_index <= '0;
                    if (op_q == CAM_OP_FILL) begin
                        if (cam_lookup_hit) begin
                            resp_hit   <= 1'b1;
                            resp_index <= cam_lookup_index;
                        end else begin
                            update_en    <= 1'b1;
                            update_valid <= 1'b1;
                            update_key   <= key_q;
                            update_index <= victim;
                            resp_index   <= victim;
                            if (!any_free) begin
                                rr_ptr <= rr_next;
                            end
                        end
                    end else if (op_q == CAM_OP_INVALIDATE) begin
                        if (cam_lookup_hit) begin
                            update_en    <= 1'b1;
                            update_valid <= 1'b0;
                            update_key   <= key_q;
                            update_index <= cam_lookup_index;
                            resp_hit     <= 1'b1;
                            resp_index   <= cam_lookup_index;
                        end
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (walk_cnt == LAST_IDX) begin
                        state  <= ST_IDLE;
                        rr_ptr <= '0;
                    end else begin
                        walk_cnt     <= walk_next;
                        update_en    <= 1'b1;
                        update_valid <= 1'b0;
                        update_key   <= '0;
                        update_index <= walk_next;
                        if (walk_next == LAST_IDX) begin
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_index <= LAST_IDX;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Local copy of the CAM valid bits, tracking every write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
        end else if (update_en) begin
            slot_valid[update_index] <= update_valid;
        end
    end

`ifndef SYNTHESIS
    // A key the probe found must never be installed a second time.
    assert property (@(posedge clk) disable iff (reset)
        (state == ST_WRITE && update_en && update_valid) |-> !hit_q);
    // A hit response always names the slot the probe reported.
    assert property (@(posedge clk) disable iff (reset)
        (state == ST_WRITE && resp_hit) |-> (resp_index == hit_idx_q));
`endif

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Bench for cam_update_ctrl with a behavioural CAM and a slot-level reference model.
// Latency: checks the accept -> update -> ready timing cycle by cycle.
// Backpressure: requests wait for req_ready; one request at a time.
module tb_cam_update_ctrl;
    import cam_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int KW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [KW-1:0] req_key = '0;
    logic [KW-1:0] cam_lookup_key;
    logic          cam_lookup_hit;
    logic [IW-1:0] cam_lookup_index;
    logic          update_en;
    logic [KW-1:0] update_key;
    logic [IW-1:0] update_index;
    logic          update_valid;
    logic          resp_valid;
    logic          resp_hit;
    logic [IW-1:0] resp_index;

    always #5 clk = ~clk;

    cam_update_ctrl #(
        .NUM_ENTRIES (N),
        .KEY_WIDTH   (KW),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_key          (req_key),
        .cam_lookup_key   (cam_lookup_key),
        .cam_lookup_hit   (cam_lookup_hit),
        .cam_lookup_index (cam_lookup_index),
        .update_en        (update_en),
        .update_key       (update_key),
        .update_index     (update_index),
        .update_valid     (update_valid),
        .resp_valid       (resp_valid),
        .resp_hit         (resp_hit),
        .resp_index       (resp_index)
    );

    // Behavioural CAM attached to the update and lookup ports.
    logic [KW-1:0] cam_key [N];
    logic [N-1:0]  cam_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cam_vld <= '0;
            for (int i = 0; i < N; i++) cam_key[i] <= '0;
        end else if (update_en) begin
            cam_key[update_index] <= update_key;
            cam_vld[update_index] <= update_valid;
        end
    end

    always_comb begin
        cam_lookup_hit   = 1'b0;
        cam_lookup_index = '0;
        for (int i = 0; i < N; i++) begin
            if (cam_vld[i] && cam_key[i] == cam_lookup_key && !cam_lookup_hit) begin
                cam_lookup_hit   = 1'b1;
                cam_lookup_index = IW'(i);
            end
        end
    end

    // Reference model: what each slot should hold, plus the eviction pointer.
    logic [KW-1:0] m_key [N];
    bit            m_vld [N];
    int            m_rr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_key[i] = '0;
        end
        m_rr = 0;
    endtask

    task automatic check_no_dups();
        int dups = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (cam_vld[i] && cam_vld[j] && cam_key[i] == cam_key[j]) dups++;
        check("cam_dup", dups, 0);
    endtask

    task automatic run_flush();
        @(negedge clk);
        check("flush_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = CAM_OP_FLUSH;
        req_key   = $urandom;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("flush_en", update_en, 1);
            check("flush_idx", update_index, i);
            check("flush_uval", update_valid, 0);
            check("flush_ukey", update_key, 0);
            check("flush_rvld", resp_valid, (i == N - 1));
            if (i == N - 1) begin
                check("flush_ridx", resp_index, N - 1);
                check("flush_rhit", resp_hit, 0);
            end
        end
        @(negedge clk);
        check("flush_end_en", update_en, 0);
        check("flush_end_rdy", req_ready, 1);
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [KW-1:0] key);
        bit e_upd  = 1'b0;
        bit e_uval = 1'b0;
        bit e_hit  = 1'b0;
        int e_idx  = 0;
        int hit_i  = -1;
        int free_i = -1;
        if (op == CAM_OP_FLUSH) begin
            run_flush();
            return;
        end
        for (int i = 0; i < N; i++) if (m_vld[i] && m_key[i] == key) hit_i = i;
        for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) free_i = i;
        if (op == CAM_OP_FILL) begin
            if (hit_i >= 0) begin
                e_hit = 1'b1;
                e_idx = hit_i;
            end else begin
                e_upd  = 1'b1;
                e_uval = 1'b1;
                if (free_i >= 0) begin
                    e_idx = free_i;
                end else begin
                    e_idx = m_rr;
                    m_rr  = (m_rr + 1) % N;
                end
                m_vld[e_idx] = 1'b1;
                m_key[e_idx] = key;
            end
        end else if (hit_i >= 0) begin
            e_upd = 1'b1;
            e_hit = 1'b1;
            e_idx = hit_i;
            m_vld[e_idx] = 1'b0;
        end

        @(negedge clk);
        check("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_key   = $urandom;
        @(negedge clk);
        check("probe_key", cam_lookup_key, key);
        check("probe_en", update_en, 0);
        check("probe_rvld", resp_valid, 0);
        check("busy_ready", req_ready, 0);
        @(negedge clk);
        check("wr_en", update_en, e_upd);
        check("wr_rvld", resp_valid, 1);
        check("wr_rhit", resp_hit, e_hit);
        check("wr_ridx", resp_index, e_idx);
        if (e_upd) begin
            check("wr_uidx", update_index, e_idx);
            check("wr_uval", update_valid, e_uval);
            check("wr_ukey", update_key, key);
        end
        @(negedge clk);
        check("done_en", update_en, 0);
        check("done_rvld", resp_valid, 0);
        check("done_ready", req_ready, 1);
        check_no_dups();
    endtask

    function automatic logic [KW-1:0] key_of(input int k);
        logic [KW-1:0] dead;
        dead = 32'hdead;
        return (k >= 8) ? dead : KW'(32'h1000 * (k + 1));
    endfunction

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_rel_ready", req_ready, 1);
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #20;
        check("rst_ready", req_ready, 1);
        check("rst_en", update_en, 0);
        check("rst_ukey", update_key, 0);
        check("rst_uidx", update_index, 0);
        check("rst_uval", update_valid, 0);
        check("rst_rvld", resp_valid, 0);
        check("rst_rhit", resp_hit, 0);
        check("rst_ridx", resp_index, 0);
        check("rst_lkey", cam_lookup_key, 0);
        release_reset();

        // Empty CAM fills, then evictions, hits, invalidates and a flush.
        run_op(CAM_OP_FILL, 32'h1000);
        run_op(CAM_OP_FILL, 32'h2000);
        run_op(CAM_OP_FILL, 32'h3000);
        run_op(CAM_OP_FILL, 32'h4000);
        run_op(CAM_OP_FILL, 32'h5000);
        run_op(CAM_OP_FILL, 32'h6000);
        run_op(CAM_OP_INVALIDATE, 32'h1000);
        run_op(CAM_OP_INVALIDATE, 32'h2000);
        run_op(CAM_OP_FILL, 32'h3000);
        run_op(CAM_OP_INVALIDATE, 32'h3000);
        run_op(CAM_OP_FILL, 32'h7000);
        run_op(CAM_OP_INVALIDATE, 32'hdead);
        run_op(CAM_OP_FLUSH, 32'h0);
        run_op(CAM_OP_FILL, 32'h1000);

        // Reset in the middle of a flush walk, with slot 1 on the update port.
        run_op(CAM_OP_FILL, 32'h2000);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = CAM_OP_FLUSH;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("mid_flush_idx", update_index, 1);
        reset = 1'b1;
        #1;
        check("rst_flush_en", update_en, 0);
        check("rst_flush_rvld", resp_valid, 0);
        check("rst_flush_ready", req_ready, 1);
        release_reset();
        run_op(CAM_OP_FILL, 32'h8000);

        // Reset while a fill is probing.
        run_op(CAM_OP_FILL, 32'h3000);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = CAM_OP_FILL;
        req_key   = 32'h4000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_probe_en", update_en, 0);
        check("rst_probe_rvld", resp_valid, 0);
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rvld", resp_valid, 0);
            check("post_rst_en", update_en, 0);
        end
        run_op(CAM_OP_FILL, 32'h4000);

        // Random mix against the reference model.
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 19);
            op = (r < 10) ? CAM_OP_FILL : (r < 19) ? CAM_OP_INVALIDATE : CAM_OP_FLUSH;
            run_op(op, key_of($urandom_range(0, 8)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_update_ctrl.md
Name: cam_update_ctrl

Overview:
Write-side controller for a content addressable memory instance. Accepts fill, invalidate and flush requests over a valid/ready handshake and probes the CAM lookup port so a key is never installed twice. Chooses a slot: lowest free slot first, otherwise a round-robin victim. Drives the CAM update port and returns a one-beat response. Sits between a TLB/tag miss handler and its CAM.

Parameters:
NUM_ENTRIES, 4, number of CAM slots (>=2)
KEY_WIDTH, 32, key width in bits
INDEX_WIDTH, $clog2(NUM_ENTRIES), slot index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  cam_op_t: FILL, INVALIDATE, FLUSH
req_key  in  KEY_WIDTH  key for FILL/INVALIDATE; ignored for FLUSH
cam_lookup_key  out  KEY_WIDTH  probe key to CAM lookup port
cam_lookup_hit  in  1  CAM hit, combinational from cam_lookup_key
cam_lookup_index  in  INDEX_WIDTH  CAM hit slot
update_en  out  1  CAM write strobe
update_key  out  KEY_WIDTH  key written
update_index  out  INDEX_WIDTH  slot written
update_valid  out  1  valid bit written
resp_valid  out  1  one-cycle completion pulse
resp_hit  out  1  key was already present (FILL/INVALIDATE)
resp_index  out  INDEX_WIDTH  slot installed, found or invalidated

Behaviour:
- Reset (async): state IDLE; slot_valid mirror all 0; rr_ptr=0; key_q=0. Outputs: req_ready=1, update_en=0, update_key=0, update_index=0, update_valid=0, resp_valid=0, resp_hit=0, resp_index=0, cam_lookup_key=0.
- Handshake: transfer when req_valid && req_ready. req_ready=1 only in IDLE. Exactly one request is in flight.
- States: IDLE, PROBE, WRITE, FLUSH.
- IDLE: on transfer, latch op_q and key_q. FLUSH goes to FLUSH with walk counter=0; otherwise go to PROBE.
- cam_lookup_key is always driven from key_q (registered).
- PROBE (1 cycle): register hit_q and hit_idx_q from the CAM, then go to WRITE.
- WRITE (1 cycle), all outputs registered out of this state:
  - FILL, hit: no update; resp_hit=1, resp_index=hit_idx_q.
  - FILL, miss: update_en=1, update_valid=1, update_key=key_q. update_index = lowest index with slot_valid=0; if all slots are valid, update_index=rr_ptr and rr_ptr increments modulo NUM_ENTRIES (wraps NUM_ENTRIES-1 -> 0). rr_ptr changes only on an eviction. resp_hit=0, resp_index=chosen slot.
  - INVALIDATE, hit: update_en=1, update_valid=0, update_index=hit_idx_q, update_key=key_q; resp_hit=1, resp_index=hit_idx_q.
  - INVALIDATE, miss: no update; resp_hit=0, resp_index=0.
  - resp_valid pulses in the same cycle as update_en. Return to IDLE.
- Latency: request accepted at cycle T -> update_en/resp_valid at T+2 -> req_ready=1 again at T+3.
- FLUSH: one slot per cycle, i=0..NUM_ENTRIES-1. Each cycle: update_en=1, update_valid=0, update_index=i, update_key=0. resp_valid=1 with resp_index=NUM_ENTRIES-1 and resp_hit=0 in the last walk cycle. rr_ptr resets to 0. Return to IDLE. Duration is NUM_ENTRIES cycles after accept.
- slot_valid mirror: updated on every update_en cycle as slot_valid[update_index] <= update_valid. Free-slot selection uses the mirror, never the CAM.
- update_en is 0 outside WRITE/FLUSH; update_key, update_index and update_valid hold their last value when update_en=0.
- Reset mid-operation: aborts immediately, returns to the reset values above, and issues no partial response. The CAM shares the reset, so the mirror and the CAM stay consistent.
- Simulation-only assertion: update_en with update_valid=1 never targets a key for which cam_lookup_hit was set during PROBE.

Decomposition:
- Package cam_ctrl_pkg: typedef enum logic[1:0] cam_op_t {CAM_OP_FILL=0, CAM_OP_INVALIDATE=1, CAM_OP_FLUSH=2}; state typedef cam_ctrl_state_t {IDLE, PROBE, WRITE, FLUSH}.
- Sub-module cam_free_slot_finder: combinational lowest-clear-bit priority encoder over slot_valid, outputs free_index and any_free.

Test Plan:
1. NUM_ENTRIES=4. After reset, FILL 0x1000, 0x2000, 0x3000, 0x4000 into an empty CAM -> update_index 0,1,2,3; resp_hit=0; each update_en exactly 2 cycles after accept.
2. CAM full, FILL 0x5000 then 0x6000 -> evicts slot 0 then slot 1 (rr_ptr 0->1->2); lookups of 0x1000 and 0x2000 now miss.
3. FILL 0x3000 when already present in slot 2 -> no update_en; resp_hit=1, resp_index=2; no duplicate-entry error from the CAM.
4. INVALIDATE 0x3000 (slot 2) -> update_en, update_valid=0, index 2, resp_hit=1. Then FILL 0x7000 -> lands in slot 2 (free slot beats rr_ptr).
5. INVALIDATE 0xdead (absent) -> no update_en; resp_hit=0. FLUSH -> 4 consecutive update_en cycles with indices 0..3, resp_valid on the 4th; subsequent FILL goes to slot 0.
6. Assert reset during the FLUSH walk at i=1, and separately during PROBE -> update_en=0 immediately, no resp_valid, req_ready=1 after reset. A following FILL goes to slot 0.
